// File: rtl/avalon_mm_pkg.sv
// ---------------------------------------------------------------------------
// avalon_mm_pkg
// Shared types and constants for the Avalon-MM master adapter that bridges
// the RISC-V load/store unit onto the mm_bridge slave port.
//   - avm_state_e      : command FSM states (IDLE, CMD)
//   - AVM_ADDR_W_DEF   : default byte-address width
//   - AVM_DATA_W_DEF   : default data width
//   - AVM_TIMEOUT_DATA : data returned to the CPU when a read is abandoned
//                        by the response watchdog (AVM_TIMEOUT_EN builds)
// ---------------------------------------------------------------------------
package avalon_mm_pkg;

  localparam int AVM_ADDR_W_DEF = 28;
  localparam int AVM_DATA_W_DEF = 32;

  localparam logic [31:0] AVM_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMD  = 1'b1
  } avm_state_e;

endpackage

// File: rtl/avalon_mm_master_if.sv
// ---------------------------------------------------------------------------
// avalon_mm_master_if
// Avalon-MM command/response signal bundle between the adapter (master) and
// the mm_bridge slave port.
//   master modport drives : avm_address, avm_read, avm_write, avm_writedata,
//                           avm_byteenable, avm_burstcount, avm_debugaccess
//   master modport samples: avm_waitrequest, avm_readdata, avm_readdatavalid
// Parameters: ADDR_W (byte address width), DATA_W (data width, byteenable is
// DATA_W/8 bits).
// ---------------------------------------------------------------------------
interface avalon_mm_master_if
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_W = AVM_ADDR_W_DEF,
  parameter int DATA_W = AVM_DATA_W_DEF
) ();

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_burstcount;
  logic                avm_debugaccess;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
           avm_burstcount, avm_debugaccess,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
           avm_burstcount, avm_debugaccess,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/avm_pending_ctr.sv
// ---------------------------------------------------------------------------
// avm_pending_ctr
// Tracks the number of reads issued on the bus whose response has not yet
// returned, and (when built with AVM_TIMEOUT_EN) a response watchdog that
// retires the oldest outstanding read if no response arrives in time.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : a read command was accepted by the bus this cycle
//   rsp         : avm_readdatavalid this cycle
//   full        : outstanding count equals MAX_PENDING
//   empty       : no read outstanding
//   room_next   : the count after this cycle's updates is below MAX_PENDING
//   unexpected  : a response arrived with nothing outstanding
//   timeout     : watchdog retires the oldest read this cycle
// Optional feature macro: AVM_TIMEOUT_EN (watchdog present when defined).
// ---------------------------------------------------------------------------
module avm_pending_ctr #(
  parameter int  MAX_PENDING = 4,
  parameter int  TIMEOUT_CYC = 1024,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic rsp,
  output logic full,
  output logic empty,
  output logic room_next,
  output logic unexpected,
  output logic timeout
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             empty_s;
  logic             dec_s;
  logic             timeout_s;

  assign empty_s = (count_r == {CNT_W{1'b0}});

  // A response only retires a read if one is actually outstanding.
  assign dec_s = (rsp && !empty_s) || timeout_s;

`ifdef AVM_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC);
  // The accept cycle itself is not seen by the counter (pending rises one
  // cycle later), so firing at TIMEOUT_CYC-2 lands the retire strobe
  // TIMEOUT_CYC-1 cycles after accept and cpu_rvalid TIMEOUT_CYC after.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

  logic [WD_W-1:0] wd_r;

  // Watchdog age: restarts on every response, retire, or while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= {WD_W{1'b0}};
    end else if (empty_s || rsp || timeout_s) begin
      wd_r <= {WD_W{1'b0}};
    end else begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  assign timeout_s = !empty_s && !rsp && (wd_r == WD_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next outstanding count; simultaneous accept and retire cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({inc, dec_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Outstanding read count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign full       = (count_r == MAX_C);
  assign empty      = empty_s;
  assign room_next  = (count_next_s < MAX_C);
  assign unexpected = rsp && empty_s;
  assign timeout    = timeout_s;

endmodule

// File: rtl/avalon_mm_master.sv
// ---------------------------------------------------------------------------
// avalon_mm_master
// Adapter from the CPU load/store request interface to an Avalon-MM master.
// Each accepted CPU request becomes a single-word read or write command that
// is held on the bus while avm_waitrequest is high. Reads may be pipelined up
// to MAX_PENDING deep; responses return in order on cpu_rvalid/cpu_rdata one
// cycle after avm_readdatavalid. Burstcount is always 1.
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_be : CPU request
//   cpu_ready  : request accepted when cpu_req & cpu_ready
//   cpu_rvalid/cpu_rdata : read data, one pulse per read
//   cpu_wdone  : pulse one cycle after a write is accepted by the bus
//   cpu_err    : sticky; unexpected response or watchdog retire
//   avm        : Avalon-MM bus (avalon_mm_master_if.master)
// Optional feature macro: AVM_TIMEOUT_EN (read-response watchdog).
// ---------------------------------------------------------------------------
module avalon_mm_master
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_W      = AVM_ADDR_W_DEF,
  parameter int DATA_W      = AVM_DATA_W_DEF,
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ready,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_wdone,
  output logic                cpu_err,
  avalon_mm_master_if.master  avm
);

  localparam int BE_W = DATA_W / 8;
  // Commands are always word aligned on the bus.
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  avm_state_e        state_r;
  avm_state_e        state_next_s;
  logic              load_s;
  logic              cpu_ready_s;
  logic              bus_acc_s;
  logic              read_acc_s;
  logic              pend_full_s;
  logic              pend_empty_s;
  logic              room_next_s;
  logic              unexpected_s;
  logic              timeout_s;
  logic              rsp_fwd_s;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;
  logic              read_r;
  logic              write_r;
  logic              rvalid_r;
  logic [DATA_W-1:0] rdata_r;
  logic              wdone_r;
  logic              err_r;

  // Kept outside the FSM block so the counter's room_next (which depends on
  // it) does not feed back into the same combinational process.
  assign bus_acc_s  = (state_r == CMD) && !avm.avm_waitrequest;
  assign read_acc_s = bus_acc_s && read_r;
  assign rsp_fwd_s  = avm.avm_readdatavalid && !pend_empty_s;

  avm_pending_ctr #(
    .MAX_PENDING (MAX_PENDING),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_pending (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .inc        (read_acc_s),
    .rsp        (avm.avm_readdatavalid),
    .full       (pend_full_s),
    .empty      (pend_empty_s),
    .room_next  (room_next_s),
    .unexpected (unexpected_s),
    .timeout    (timeout_s)
  );

  // FSM next state, CPU handshake and command-capture strobe.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    cpu_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cpu_ready_s = !pend_full_s;
        if (cpu_req && cpu_ready_s) begin
          load_s       = 1'b1;
          state_next_s = CMD;
        end else begin
          state_next_s = IDLE;
        end
      end
      CMD: begin
        if (avm.avm_waitrequest) begin
          cpu_ready_s  = 1'b0;
          state_next_s = CMD;
        end else begin
          // Command leaves the bus now; a new one may replace it directly,
          // judged against the outstanding count after this cycle.
          cpu_ready_s = room_next_s;
          if (cpu_req && cpu_ready_s) begin
            load_s       = 1'b1;
            state_next_s = CMD;
          end else begin
            state_next_s = IDLE;
          end
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command registers: captured on accept, held while the slave stalls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
      read_r  <= 1'b0;
      write_r <= 1'b0;
    end else if (load_s) begin
      addr_r  <= cpu_addr & ADDR_MASK;
      wdata_r <= cpu_wdata;
      be_r    <= cpu_be;
      read_r  <= !cpu_we;
      write_r <= cpu_we;
    end else if (bus_acc_s) begin
      read_r  <= 1'b0;
      write_r <= 1'b0;
    end
  end

  // CPU-side response registers and the sticky error flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
      wdone_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= rsp_fwd_s || timeout_s;
      if (rsp_fwd_s) begin
        rdata_r <= avm.avm_readdata;
      end else if (timeout_s) begin
        rdata_r <= DATA_W'(AVM_TIMEOUT_DATA);
      end
      wdone_r <= bus_acc_s && write_r;
      if (unexpected_s || timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign cpu_ready  = cpu_ready_s;
  assign cpu_rvalid = rvalid_r;
  assign cpu_rdata  = rdata_r;
  assign cpu_wdone  = wdone_r;
  assign cpu_err    = err_r;

  assign avm.avm_address     = addr_r;
  assign avm.avm_read        = read_r;
  assign avm.avm_write       = write_r;
  assign avm.avm_writedata   = wdata_r;
  assign avm.avm_byteenable  = be_r;
  assign avm.avm_burstcount  = 1'b1;
  assign avm.avm_debugaccess = 1'b0;

endmodule
